// File: rtl/axi_lite_mmio_master.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_mmio_master
// Brief    : Single-outstanding request/response port to AXI4-Lite initiator
//            with a per-transaction watchdog.
// Revision : 1.0
// ============================================================================
module axi_lite_mmio_master #(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [2:0]  AXI_PROT       = 3'b000
) (
    input  logic        aclk,
    input  logic        arst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [31:0] M_AXI_awaddr,
    output logic [2:0]  M_AXI_awprot,
    output logic        M_AXI_awvalid,
    input  logic        M_AXI_awready,
    output logic [31:0] M_AXI_wdata,
    output logic [3:0]  M_AXI_wstrb,
    output logic        M_AXI_wvalid,
    input  logic        M_AXI_wready,
    input  logic [1:0]  M_AXI_bresp,
    input  logic        M_AXI_bvalid,
    output logic        M_AXI_bready,
    output logic [31:0] M_AXI_araddr,
    output logic [2:0]  M_AXI_arprot,
    output logic        M_AXI_arvalid,
    input  logic        M_AXI_arready,
    input  logic [31:0] M_AXI_rdata,
    input  logic [1:0]  M_AXI_rresp,
    input  logic        M_AXI_rvalid,
    output logic        M_AXI_rready
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_AW_W = 3'd1;
    localparam logic [2:0] WR_B    = 3'd2;
    localparam logic [2:0] RD_AR   = 3'd3;
    localparam logic [2:0] RD_R    = 3'd4;
    localparam logic [2:0] RESP    = 3'd5;

    // Counter saturates at TIMEOUT_CYCLES-1; the cycle that would reach the limit fires.
    localparam int             WD_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam bit             WD_EN    = (TIMEOUT_CYCLES > 0);

    logic [2:0]      state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      wstrb_q, wstrb_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            arvalid_q, arvalid_d;
    logic            bready_q, bready_d;
    logic            rready_q, rready_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_resp_q, rsp_resp_d;
    logic            rsp_timeout_q, rsp_timeout_d;
    logic [WD_W-1:0] wdog_q, wdog_d;

    logic w_busy;
    logic w_wd_fire;
    logic w_expire;
    logic w_aw_hs;
    logic w_w_hs;

    assign w_busy    = (state_q == WR_AW_W) || (state_q == WR_B) ||
                       (state_q == RD_AR)   || (state_q == RD_R);
    assign w_wd_fire = WD_EN && (wdog_q >= WD_LIMIT);
    assign w_aw_hs   = awvalid_q & M_AXI_awready;
    assign w_w_hs    = wvalid_q & M_AXI_wready;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        arvalid_d     = arvalid_q;
        bready_d      = bready_q;
        rready_d      = rready_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        wdog_d        = wdog_q;
        w_expire      = 1'b0;

        if (w_busy && (wdog_q < WD_LIMIT)) begin
            wdog_d = wdog_q + WD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_ready_d   = 1'b0;
                    addr_d        = req_addr;
                    wdata_d       = req_wdata;
                    wstrb_d       = req_wstrb;
                    wdog_d        = '0;
                    rsp_timeout_d = 1'b0;
                    if (req_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_AW_W;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = RD_AR;
                    end
                end
            end
            WR_AW_W: begin
                // A deasserted valid doubles as that channel's done flag.
                awvalid_d = awvalid_q & ~M_AXI_awready;
                wvalid_d  = wvalid_q & ~M_AXI_wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_B;
                end else if (w_wd_fire && !(w_aw_hs || w_w_hs)) begin
                    w_expire = 1'b1;
                end
            end
            WR_B: begin
                if (bready_q && M_AXI_bvalid) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (w_wd_fire) begin
                    w_expire = 1'b1;
                end
            end
            RD_AR: begin
                if (arvalid_q && M_AXI_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_R;
                end else if (w_wd_fire) begin
                    w_expire = 1'b1;
                end
            end
            RD_R: begin
                if (rready_q && M_AXI_rvalid) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = M_AXI_rresp;
                    rsp_rdata_d = M_AXI_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (w_wd_fire) begin
                    w_expire = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        if (w_expire) begin
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            arvalid_d     = 1'b0;
            bready_d      = 1'b0;
            rready_d      = 1'b0;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = 2'b10;
            rsp_rdata_d   = '0;
            rsp_valid_d   = 1'b1;
            state_d       = RESP;
        end
    end

    always_ff @(posedge aclk) begin
        if (!arst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            req_ready_q   <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            wdog_q        <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            bready_q      <= bready_d;
            rready_q      <= rready_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            wdog_q        <= wdog_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_resp      = rsp_resp_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign M_AXI_awaddr  = addr_q;
    assign M_AXI_awprot  = AXI_PROT;
    assign M_AXI_awvalid = awvalid_q;
    assign M_AXI_wdata   = wdata_q;
    assign M_AXI_wstrb   = wstrb_q;
    assign M_AXI_wvalid  = wvalid_q;
    assign M_AXI_bready  = bready_q;
    assign M_AXI_araddr  = addr_q;
    assign M_AXI_arprot  = AXI_PROT;
    assign M_AXI_arvalid = arvalid_q;
    assign M_AXI_rready  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_mmio_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_mmio_master
// Brief    : Directed and randomized checks of axi_lite_mmio_master against
//            a latency/response reference model.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_mmio_master;

    localparam int TO = 16;

    logic        aclk = 1'b0;
    logic        arst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    int n_cmp = 0;
    int n_err = 0;

    axi_lite_mmio_master #(.TIMEOUT_CYCLES(TO), .AXI_PROT(3'b000)) dut (
        .aclk(aclk), .arst_n(arst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .M_AXI_awaddr(awaddr), .M_AXI_awprot(awprot), .M_AXI_awvalid(awvalid),
        .M_AXI_awready(awready), .M_AXI_wdata(wdata), .M_AXI_wstrb(wstrb),
        .M_AXI_wvalid(wvalid), .M_AXI_wready(wready), .M_AXI_bresp(bresp),
        .M_AXI_bvalid(bvalid), .M_AXI_bready(bready), .M_AXI_araddr(araddr),
        .M_AXI_arprot(arprot), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
        .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rvalid(rvalid),
        .M_AXI_rready(rready)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0; bresp = '0; rresp = '0; rdata = '0;
    endtask

    // One request/response round trip. Iteration k observes the outputs
    // during cycle k after acceptance and drives the slave for edge k.
    task automatic do_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] ws, input int aw_dly, input int w_dly,
                          input int ar_dly, input int resp_dly, input logic [1:0] sresp,
                          input logic [31:0] srdata, input int hold, input bit poke);
        int hs, exp_cyc, rsp_cyc, wait_n, viol, stab, ar_high;
        int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, aw_e, w_e, ar_e, dmax;
        bit exp_to, got;
        logic [31:0] exp_rdata, p_rdata;
        logic [1:0]  exp_resp, p_resp;
        logic        p_to;
        logic [19:0] beats, exp_beats;

        // Reference model: handshake edge and resulting response.
        if (wr) hs = ((aw_dly > w_dly) ? aw_dly : w_dly) + 2 + resp_dly;
        else    hs = ar_dly + 2 + resp_dly;
        exp_to    = (hs > TO);
        exp_cyc   = exp_to ? TO + 1 : hs + 1;
        exp_rdata = (exp_to || wr) ? 32'h0 : srdata;
        exp_resp  = exp_to ? 2'b10 : sresp;
        if (wr) exp_beats = {4'd1, 4'd1, exp_to ? 4'd0 : 4'd1, 4'd0, 4'd0};
        else    exp_beats = {4'd0, 4'd0, 4'd0, (ar_dly + 1 <= TO) ? 4'd1 : 4'd0,
                             exp_to ? 4'd0 : 4'd1};

        req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = ws;
        req_valid = 1'b1;
        wait_n = 0;
        while (req_ready !== 1'b1 && wait_n < 20) begin
            step();
            wait_n++;
        end
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        chk("req_taken", 32'(req_ready), 32'd0);
        chk("timeout_clear", 32'(rsp_timeout), 32'd0);

        viol = 0; stab = 0; ar_high = 0; got = 0; rsp_cyc = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_e = 0; w_e = 0; ar_e = 0;
        for (int k = 1; k <= 40; k++) begin
            if (rsp_valid === 1'b1) begin
                got = 1;
                rsp_cyc = k;
                break;
            end
            if (req_ready !== 1'b0) viol++;
            if (awvalid === 1'b1 && (aw_cnt > 0 || !wr || awaddr !== addr)) viol++;
            if (wvalid === 1'b1 && (w_cnt > 0 || !wr || wdata !== wd || wstrb !== ws)) viol++;
            if (arvalid === 1'b1 && (ar_cnt > 0 || wr || araddr !== addr)) viol++;
            if (bready === 1'b1 && !(aw_cnt > 0 && w_cnt > 0)) viol++;
            if (rready === 1'b1 && ar_cnt == 0) viol++;
            if (awprot !== 3'b000 || arprot !== 3'b000) viol++;
            if (arvalid === 1'b1) ar_high++;

            dmax    = (aw_e > w_e) ? aw_e : w_e;
            awready = (k > aw_dly);
            wready  = (k > w_dly);
            arready = (k > ar_dly);
            bvalid  = (aw_cnt > 0 && w_cnt > 0 && b_cnt == 0 && k >= dmax + 1 + resp_dly);
            bresp   = sresp;
            rvalid  = (ar_cnt > 0 && r_cnt == 0 && k >= ar_e + 1 + resp_dly);
            rdata   = rvalid ? srdata : $urandom;
            rresp   = rvalid ? sresp : 2'b01;

            if (awvalid === 1'b1 && awready) begin aw_cnt++; aw_e = k; end
            if (wvalid === 1'b1 && wready) begin w_cnt++; w_e = k; end
            if (arvalid === 1'b1 && arready) begin ar_cnt++; ar_e = k; end
            if (bvalid && bready === 1'b1) b_cnt++;
            if (rvalid && rready === 1'b1) r_cnt++;
            step();
        end
        slave_idle();

        beats = {aw_cnt[3:0], w_cnt[3:0], b_cnt[3:0], ar_cnt[3:0], r_cnt[3:0]};
        chk("rsp_seen", 32'(got), 32'd1);
        chk("rsp_latency", 32'(rsp_cyc), 32'(exp_cyc));
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
        chk("beats", 32'(beats), 32'(exp_beats));
        chk("protocol", 32'(viol), 32'd0);
        if (exp_to && !wr) chk("arvalid_cycles", 32'(ar_high), 32'(TO));

        p_rdata = rsp_rdata; p_resp = rsp_resp; p_to = rsp_timeout;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            req_valid = poke;
            if (rsp_valid !== 1'b1 || rsp_rdata !== p_rdata || rsp_resp !== p_resp ||
                rsp_timeout !== p_to || req_ready !== 1'b0) stab++;
            step();
        end
        rsp_ready = 1'b1;
        req_valid = poke;
        chk("req_ready_in_resp", 32'(req_ready), 32'd0);
        chk("rsp_stable", 32'(stab), 32'd0);
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("req_ready_after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int r;
        logic [1:0] rs;

        // Reset state
        arst_n = 1'b0;
        step(); step(); step();
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_axi_hs", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        chk("rst_rsp_payload", 32'({rsp_rdata != 32'h0, rsp_resp, rsp_timeout}), 32'd0);
        chk("rst_addr", awaddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        arst_n = 1'b1;
        step();

        // Zero-wait write
        do_txn(1'b1, 32'h4600_0104, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0, 1'b0);
        // Skewed AW/W: W ready 3 cycles after AW
        do_txn(1'b1, 32'h4600_0108, 32'hA5A5_0001, 4'h3, 0, 3, 0, 0, 2'b00, 32'h0, 1, 1'b0);
        // Read with DECERR, rvalid 5 cycles after AR
        do_txn(1'b0, 32'h4600_0F00, 32'h0, 4'h0, 0, 0, 0, 5, 2'b11, 32'h1234_5678, 0, 1'b0);
        // Response backpressure with a waiting requester
        do_txn(1'b0, 32'h4600_0010, 32'h0, 4'h0, 1, 0, 1, 1, 2'b00, 32'hCAFE_F00D, 4, 1'b1);
        // Watchdog: AR never accepted
        do_txn(1'b0, 32'h4600_0020, 32'h0, 4'h0, 0, 0, 1000, 0, 2'b00, 32'h0, 2, 1'b0);
        // Next read to a live slave
        do_txn(1'b0, 32'h4600_0024, 32'h0, 4'h0, 0, 0, 2, 0, 2'b00, 32'h0BAD_CAFE, 0, 1'b0);

        // Reset during WR_B
        req_write = 1'b1; req_addr = 32'h4600_0200; req_wdata = 32'h1111_2222; req_wstrb = 4'hF;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("mid_awvalid", 32'(awvalid), 32'd1);
        awready = 1'b1; wready = 1'b1;
        step();
        chk("mid_bready", 32'(bready), 32'd1);
        slave_idle();
        arst_n = 1'b0;
        step();
        arst_n = 1'b1;
        chk("mid_rst_axi", 32'({awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        do_txn(1'b1, 32'h4600_0204, 32'h3333_4444, 4'hC, 1, 0, 0, 2, 2'b10, 32'h0, 0, 1'b0);

        // Randomized transactions
        for (int i = 0; i < 10; i++) begin
            r  = $urandom_range(0, 2);
            rs = (r == 0) ? 2'b00 : ((r == 1) ? 2'b10 : 2'b11);
            do_txn(1'($urandom_range(0, 1)), 32'h4600_0000 | ($urandom & 32'h0000_FFFC),
                   $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5),
                   $urandom_range(0, 4), rs, $urandom, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
